ann_loader: RTL and testbench
=============================

# ann_loader

Upstream sequencer for the 2x2 ANN datapath (`mul_matr`). It accepts a valid/ready word stream and drives the datapath's `mat_sel`/`adr`/`w2` write port, one element per beat. A full load covers the input matrix, hidden weights and output weights; a fast load refreshes only the input matrix and keeps the resident weights. After the final element is written it reports frame completion, the cycle in which `decision` is valid.

## Interface
- `DATA_W`, default 21: stream and `w2` width (signed).
- `NARROW_W`, default 11: storage width of the input and hidden-weight matrices (signed).
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a frame; sampled in IDLE only.
- `keep_w`, in, 1: sampled with `start`. 1 loads the input matrix only (4 beats); 0 does a full load (12 beats).
- `s_data`, in, DATA_W: signed element word.
- `s_valid`, in, 1: `s_data` valid.
- `s_ready`, out, 1: loader accepts a beat.
- `mat_sel`, out, 2: datapath matrix select. 00 input, 01 hidden weights, 10 output weights, 11 no write.
- `adr`, out, 2: element address; `adr[1]` is the row, `adr[0]` the column.
- `w2`, out, DATA_W: element value to the datapath.
- `busy`, out, 1: a frame is in progress.
- `frame_done`, out, 1: one-cycle pulse; the datapath `decision` reflects the completed frame.
- `frame_cnt`, out, 8: count of completed frames; wraps 255 -> 0.
- `sat_flag`, out, 1: sticky saturation indicator. Present only with `ANN_LOADER_RANGE_CHK_EN`.

## Operation
- States: IDLE, LD_IN, LD_W1, LD_W2, FLUSH.
- IDLE -> LD_IN on `start`. The element counter clears and `keep_w` is latched.
- Each state accepts exactly 4 beats, row-major, `adr` 00, 01, 10, 11.
- LD_IN -> FLUSH after 4 beats if latched `keep_w`=1, else LD_IN -> LD_W1.
- LD_W1 -> LD_W2 after 4 beats.
- LD_W2 -> FLUSH after 4 beats.
- FLUSH -> IDLE after 1 cycle. FLUSH pulses `frame_done` and increments `frame_cnt`.
- `s_ready` = 1 in LD_IN, LD_W1 and LD_W2; 0 in IDLE and FLUSH.
- A beat transfers when `s_valid` & `s_ready`.
- `mat_sel`, `adr` and `w2` are registered.
  - On the cycle after a transfer they carry that beat's element.
  - Every other cycle `mat_sel` = 11. This is mandatory: the datapath rewrites on every clock while `mat_sel` matches a matrix.
- `adr` and `w2` hold their last values when `mat_sel` = 11.
- `s_valid` low inside a load state: stall with no write and no state change. Stalls of any length are legal.
- `start` while `busy` is ignored. `start` and `s_valid` in the same IDLE cycle: no transfer (`s_ready` = 0).
- `busy` = 1 from the cycle after `start` until FLUSH completes.
- Reset values: state IDLE, `s_ready` 0, `mat_sel` 11, `adr` 00, `w2` 0, `busy` 0, `frame_done` 0, `frame_cnt` 0, `sat_flag` 0.
- Reset mid-frame: return to IDLE and issue no further writes. Partially loaded datapath contents are left as is. No `frame_done` is issued.

## Timing
- Transfer at edge N -> write strobe (`mat_sel` != 11) during cycle N+1 -> datapath captures at edge N+2.
- Last beat at edge N -> FLUSH during cycle N+1, write committed at edge N+2 -> `frame_done` high during cycle N+2.
- Throughput: 1 element per cycle.
- Minimum frame duration from `start` to `frame_done`: 14 cycles for a full load, 6 cycles for a fast load.
- Back-to-back: `start` is accepted in the cycle after `frame_done`.

## Configuration
- `ANN_LOADER_RANGE_CHK_EN` defined:
  - Beats for `mat_sel` 00 and 01 are saturated to the signed NARROW_W range, -1024..1023, before driving `w2`.
  - Any clipped beat sets `sat_flag`, which clears only on `rst`.
  - Beats for `mat_sel` 10 pass unchanged.
- Not defined: every beat passes unchanged to `w2`, and the `sat_flag` port is absent.

## Structure
- Shared package `ann_pkg` holds:
  - `mat_sel` codes: MAT_IN, MAT_W1, MAT_W2, MAT_NONE.
  - The state enum.
  - DATA_W and NARROW_W defaults.
- One sub-module, `ann_sat`: combinational signed saturator (DATA_W to NARROW_W range, clip flag). Instantiated only under the macro.

## Test plan
- Full load, 12 beats 1..12 streamed with no gaps -> writes (00,00..11 = 1..4), (01 = 5..8), (10 = 9..12) on consecutive cycles; `frame_done` 14 cycles after `start`; `frame_cnt` = 1.
- Fast load (`keep_w` = 1), beats -4, 15, 2, 4 -> only `mat_sel` 00 writes occur; `frame_done` 6 cycles after `start`; `mat_sel` = 11 all other cycles.
- Random `s_valid` gaps during a full load -> `mat_sel` = 11 on every stall cycle; element order unchanged; exactly 12 write strobes.
- `rst` asserted after beat 6 -> the next cycle shows IDLE, `mat_sel` 11, `busy` 0, no `frame_done`. A new `start` then begins at `adr` 00, `mat_sel` 00.
- With the macro: beats 2000 and -5000 in LD_IN -> `w2` = 1023 and -1024, `sat_flag` = 1. Beat 2000 in LD_W2 -> `w2` = 2000.
- 256 back-to-back fast frames -> `frame_cnt` wraps to 0; `start` accepted in the cycle after each `frame_done`.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared definitions for the ANN loader: datapath matrix-select codes,
// loader state encoding and default widths.
package ann_pkg;

    localparam int unsigned DATA_W_DEF   = 21;
    localparam int unsigned NARROW_W_DEF = 11;

    localparam logic [1:0] MAT_IN   = 2'b00;
    localparam logic [1:0] MAT_W1   = 2'b01;
    localparam logic [1:0] MAT_W2   = 2'b10;
    localparam logic [1:0] MAT_NONE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LD_IN = 3'd1,
        ST_LD_W1 = 3'd2,
        ST_LD_W2 = 3'd3,
        ST_FLUSH = 3'd4
    } state_e;

endpackage

// File: rtl/ann_sat.sv
// Combinational signed saturator: clamps a DATA_W word to the signed
// NARROW_W range and flags when clipping happened.
module ann_sat #(
    parameter int unsigned DATA_W   = ann_pkg::DATA_W_DEF,
    parameter int unsigned NARROW_W = ann_pkg::NARROW_W_DEF
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data_c,
    output logic              o_clip_c
);

    localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'((64'sd1 <<< (NARROW_W - 1)) - 64'sd1);
    localparam logic signed [DATA_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [DATA_W-1:0] w_in;

    assign w_in = $signed(i_data);

    always_comb begin
        o_data_c = i_data;
        o_clip_c = 1'b0;
        if (w_in > SAT_MAX) begin
            o_data_c = SAT_MAX;
            o_clip_c = 1'b1;
        end else if (w_in < SAT_MIN) begin
            o_data_c = SAT_MIN;
            o_clip_c = 1'b1;
        end
    end

endmodule

// File: rtl/ann_loader.sv
// Stream-to-datapath sequencer for the 2x2 ANN: writes input matrix and
// (optionally) both weight matrices one element per beat. ANN_LOADER_RANGE_CHK_EN
// enables saturation of narrow-matrix beats and the sticky sat_flag output.
module ann_loader
    import ann_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NARROW_W = NARROW_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              keep_w,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [1:0]        mat_sel,
    output logic [1:0]        adr,
    output logic [DATA_W-1:0] w2,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt
`ifdef ANN_LOADER_RANGE_CHK_EN
    ,
    output logic              sat_flag
`endif
);

    if (NARROW_W < 2 || NARROW_W > DATA_W) begin : g_param_chk
        $error("ann_loader: NARROW_W must be in 2..DATA_W");
    end

    state_e            r_state;
    state_e            w_state_nxt;
    logic [1:0]        r_cnt;
    logic              r_keep_w;
    logic              r_s_ready;
    logic [1:0]        r_mat_sel;
    logic [1:0]        r_adr;
    logic [DATA_W-1:0] r_w2;
    logic              r_busy;
    logic              r_frame_done;
    logic [7:0]        r_frame_cnt;
    logic [1:0]        w_mat_cur;
    logic              w_xfer;
    logic              w_last;
    logic [DATA_W-1:0] w_data;

    assign w_xfer = s_valid & r_s_ready;
    assign w_last = w_xfer & (r_cnt == 2'd3);

    // Next state and the matrix targeted by a beat accepted this cycle
    always_comb begin
        w_state_nxt = r_state;
        w_mat_cur   = MAT_NONE;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_LD_IN;
            end
            ST_LD_IN: begin
                w_mat_cur = MAT_IN;
                if (w_last) w_state_nxt = r_keep_w ? ST_FLUSH : ST_LD_W1;
            end
            ST_LD_W1: begin
                w_mat_cur = MAT_W1;
                if (w_last) w_state_nxt = ST_LD_W2;
            end
            ST_LD_W2: begin
                w_mat_cur = MAT_W2;
                if (w_last) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef ANN_LOADER_RANGE_CHK_EN
    logic [DATA_W-1:0] w_sat_data;
    logic              w_clip;
    logic              w_narrow;
    logic              r_sat_flag;

    ann_sat #(
        .DATA_W   (DATA_W),
        .NARROW_W (NARROW_W)
    ) u_sat (
        .i_data   (s_data),
        .o_data_c (w_sat_data),
        .o_clip_c (w_clip)
    );

    // Output weights keep full precision; only the narrow matrices saturate
    assign w_narrow = (w_mat_cur == MAT_IN) || (w_mat_cur == MAT_W1);
    assign w_data   = w_narrow ? w_sat_data : s_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_flag <= 1'b0;
        end else if (w_xfer && w_narrow && w_clip) begin
            r_sat_flag <= 1'b1;
        end
    end

    assign sat_flag = r_sat_flag;
`else
    assign w_data = s_data;
`endif

    // State register plus registered datapath write port and status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 2'd0;
            r_keep_w     <= 1'b0;
            r_s_ready    <= 1'b0;
            r_mat_sel    <= MAT_NONE;
            r_adr        <= 2'd0;
            r_w2         <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_s_ready    <= (w_state_nxt == ST_LD_IN) || (w_state_nxt == ST_LD_W1) ||
                            (w_state_nxt == ST_LD_W2);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_frame_done <= (r_state == ST_FLUSH);
            // Strobe must drop to MAT_NONE on any non-transfer cycle
            r_mat_sel    <= w_xfer ? w_mat_cur : MAT_NONE;
            if (r_state == ST_FLUSH) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (r_state == ST_IDLE && start) begin
                r_cnt    <= 2'd0;
                r_keep_w <= keep_w;
            end
            if (w_xfer) begin
                r_adr <= r_cnt;
                r_w2  <= w_data;
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    assign s_ready    = r_s_ready;
    assign mat_sel    = r_mat_sel;
    assign adr        = r_adr;
    assign w2         = r_w2;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_ann_loader.sv
// Self-checking bench for ann_loader: frame-level behavioural model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_ann_loader;

    localparam int unsigned DW = 21;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          keep_w = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [1:0]    mat_sel;
    logic [1:0]    adr;
    logic [DW-1:0] w2;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_cnt;
`ifdef ANN_LOADER_RANGE_CHK_EN
    logic          sat_flag;
`endif

    ann_loader #(.DATA_W(21), .NARROW_W(11)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .keep_w     (keep_w),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .mat_sel    (mat_sel),
        .adr        (adr),
        .w2         (w2),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
`ifdef ANN_LOADER_RANGE_CHK_EN
        ,
        .sat_flag   (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, $signed(act), act, $signed(exp), exp, cyc);
        end
    endtask

    // Frame-level model: counts accepted beats, element k goes to matrix k/4, address k%4
    logic          m_valid = 1'b0;
    logic          m_busy  = 1'b0;
    logic          m_flush = 1'b0;
    int            m_n     = 0;
    int            m_total = 0;
    int            e_mat   = 3;
    int            e_adr   = 0;
    logic [DW-1:0] e_w2    = '0;
    logic          e_done  = 1'b0;
    int            e_cnt   = 0;
    logic          e_sat   = 1'b0;

    function automatic logic [DW-1:0] mdl_val(input logic [DW-1:0] d, input int mat,
                                               inout logic sat);
        int v;
        v = int'($signed(d));
`ifdef ANN_LOADER_RANGE_CHK_EN
        if (mat < 2) begin
            if (v > 1023)  begin v = 1023;  sat = 1'b1; end
            if (v < -1024) begin v = -1024; sat = 1'b1; end
        end
`else
        if (mat > 3) sat = 1'b1;
`endif
        return DW'(v);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_flush = 1'b0;
            m_n     = 0;
            m_total = 0;
            e_mat   = 3;
            e_adr   = 0;
            e_w2    = '0;
            e_done  = 1'b0;
            e_cnt   = 0;
            e_sat   = 1'b0;
        end else begin
            e_done = 1'b0;
            e_mat  = 3;
            if (!m_busy) begin
                if (start) begin
                    m_busy  = 1'b1;
                    m_flush = 1'b0;
                    m_n     = 0;
                    m_total = keep_w ? 4 : 12;
                end
            end else if (m_flush) begin
                m_busy  = 1'b0;
                m_flush = 1'b0;
                e_done  = 1'b1;
                e_cnt   = (e_cnt + 1) % 256;
            end else if (s_valid) begin
                e_mat = m_n / 4;
                e_adr = m_n % 4;
                e_w2  = mdl_val(s_data, e_mat, e_sat);
                m_n++;
                if (m_n == m_total) m_flush = 1'b1;
            end
        end
    end

    // Write log for the directed checks
    int q_mat[$];
    int q_adr[$];
    int q_w2[$];
    int q_cyc[$];

    always @(negedge clk) begin
        if (m_valid) begin
            chk("s_ready", 32'(s_ready), 32'(m_busy && !m_flush));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("mat_sel", 32'(mat_sel), 32'(e_mat));
            chk("adr", 32'(adr), 32'(e_adr));
            chk("w2", 32'(w2), 32'(e_w2));
            chk("frame_done", 32'(frame_done), 32'(e_done));
            chk("frame_cnt", 32'(frame_cnt), 32'(e_cnt));
`ifdef ANN_LOADER_RANGE_CHK_EN
            chk("sat_flag", 32'(sat_flag), 32'(e_sat));
`endif
            if (mat_sel != 2'b11) begin
                q_mat.push_back(int'(mat_sel));
                q_adr.push_back(int'(adr));
                q_w2.push_back(int'($signed(w2)));
                q_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        q_mat.delete();
        q_adr.delete();
        q_w2.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start(input logic k, output int es);
        start  = 1'b1;
        keep_w = k;
        tick();
        start  = 1'b0;
        keep_w = 1'b0;
        es     = cyc;
    endtask

    task automatic beat(input int v);
        s_valid = 1'b1;
        s_data  = DW'(v);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        bit found = 0;
        dc = -1;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (frame_done === 1'b1) begin
                dc    = cyc;
                found = 1;
            end
        end
        if (!found) chk("frame_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int es;
        int dc;
        int fb[4];
        int i;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_mat_sel", 32'(mat_sel), 32'd3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_w2", 32'(w2), 32'd0);

        // Full load, no gaps
        clr_log();
        do_start(1'b0, es);
        for (int k = 1; k <= 12; k++) beat(k);
        wait_done(dc);
        chk("full_latency", 32'(dc - es + 1), 32'd14);
        chk("full_writes", 32'(q_w2.size()), 32'd12);
        if (q_w2.size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                chk("full_mat", 32'(q_mat[k]), 32'(k / 4));
                chk("full_adr", 32'(q_adr[k]), 32'(k % 4));
                chk("full_w2", 32'(q_w2[k]), 32'(k + 1));
                chk("full_consec", 32'(q_cyc[k] - q_cyc[0]), 32'(k));
            end
        end
        chk("full_frame_cnt", 32'(frame_cnt), 32'd1);

        // Fast load
        tick();
        clr_log();
        fb = '{-4, 15, 2, 4};
        do_start(1'b1, es);
        for (int k = 0; k < 4; k++) beat(fb[k]);
        wait_done(dc);
        chk("fast_latency", 32'(dc - es + 1), 32'd6);
        chk("fast_writes", 32'(q_w2.size()), 32'd4);
        if (q_w2.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("fast_mat", 32'(q_mat[k]), 32'd0);
                chk("fast_adr", 32'(q_adr[k]), 32'(k));
                chk("fast_w2", 32'(q_w2[k]), 32'(fb[k]));
            end
        end
        chk("fast_frame_cnt", 32'(frame_cnt), 32'd2);

        // Full load with random valid gaps
        tick();
        clr_log();
        do_start(1'b0, es);
        i = 1;
        while (i <= 12) begin
            if ($urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                tick();
            end else begin
                beat(100 + i);
                i++;
            end
        end
        wait_done(dc);
        chk("gap_writes", 32'(q_w2.size()), 32'd12);
        if (q_w2.size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                chk("gap_mat", 32'(q_mat[k]), 32'(k / 4));
                chk("gap_w2", 32'(q_w2[k]), 32'(101 + k));
            end
        end
        chk("gap_frame_cnt", 32'(frame_cnt), 32'd3);

        // Reset after beat 6
        tick();
        do_start(1'b0, es);
        for (int k = 1; k <= 6; k++) beat(k);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_mat_sel", 32'(mat_sel), 32'd3);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(frame_done), 32'd0);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        tick();
        do_start(1'b0, es);
        beat(77);
        chk("restart_mat_sel", 32'(mat_sel), 32'd0);
        chk("restart_adr", 32'(adr), 32'd0);
        chk("restart_w2", 32'(w2), 32'd77);
        for (int k = 2; k <= 12; k++) beat(k);
        wait_done(dc);
        chk("restart_frame_cnt", 32'(frame_cnt), 32'd1);

`ifdef ANN_LOADER_RANGE_CHK_EN
        // Saturation of narrow matrices only
        tick();
        do_reset();
        clr_log();
        do_start(1'b0, es);
        beat(2000);
        beat(-5000);
        for (int k = 2; k < 8; k++) beat(0);
        beat(2000);
        for (int k = 9; k < 12; k++) beat(0);
        wait_done(dc);
        chk("sat_writes", 32'(q_w2.size()), 32'd12);
        if (q_w2.size() == 12) begin
            chk("sat_hi", 32'(q_w2[0]), 32'd1023);
            chk("sat_lo", 32'(q_w2[1]), 32'(-1024));
            chk("sat_w2_pass", 32'(q_w2[8]), 32'd2000);
        end
        chk("sat_flag_set", 32'(sat_flag), 32'd1);
`endif

        // 256 back-to-back fast frames, start in the cycle after each frame_done
        tick();
        do_reset();
        for (int f = 0; f < 256; f++) begin
            do_start(1'b1, es);
            chk("b2b_accepted", 32'(busy), 32'd1);
            for (int k = 0; k < 4; k++) beat(f + k);
            wait_done(dc);
            chk("b2b_latency", 32'(dc - es + 1), 32'd6);
            if (f == 254) chk("b2b_cnt_255", 32'(frame_cnt), 32'd255);
            tick();
        end
        chk("b2b_wrap", 32'(frame_cnt), 32'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
